// File: rtl/whack_pkg.sv
// -----------------------------------------------------------------------------
// whack_pkg
// Shared types and constants for the whack-a-mole round controller:
//   state_t     - round controller FSM states
//   LFSR_TAPS   - feedback mask for x^8+x^6+x^5+x^4+1 (bits 7,5,4,3)
//   SCORE_W     - score width
//   INTERVAL_W  - timer interval width
//   lfsr_step() - one shift of the 8-bit Fibonacci LFSR
// -----------------------------------------------------------------------------
package whack_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT,
    HIT,
    MISS,
    OVER
  } state_t;

  localparam logic [7:0] LFSR_TAPS  = 8'hB8;
  localparam int         SCORE_W    = 8;
  localparam int         INTERVAL_W = 3;

  // Shift left, XOR of the tapped bits enters at bit 0.
  function automatic logic [7:0] lfsr_step(input logic [7:0] value);
    return {value[6:0], ^(value & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/whack_round_ctrl_if.sv
// -----------------------------------------------------------------------------
// whack_round_ctrl_if
// Link between the round controller and the countdown timer/display block.
//   reset_signal - timer re-arm (high: timer reloads interval)
//   interval     - timer load value
//   dir          - timer direction (0 = count down)
//   timeout      - one-cycle pulse from the timer when the countdown expires
// master: round controller side; slave: timer side.
// -----------------------------------------------------------------------------
interface whack_round_ctrl_if;
  import whack_pkg::*;

  logic                  reset_signal;
  logic [INTERVAL_W-1:0] interval;
  logic                  dir;
  logic                  timeout;

  modport master (
    output reset_signal,
    output interval,
    output dir,
    input  timeout
  );

  modport slave (
    input  reset_signal,
    input  interval,
    input  dir,
    output timeout
  );

endinterface

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Two-flop synchronizer followed by a stability counter. The accepted level
// flips only after DEB_CYCLES consecutive synchronized samples that all differ
// from the current level; a one-cycle press pulse marks an accepted 0->1 edge.
// Raw edge to press pulse latency is 2 + DEB_CYCLES cycles.
//   clk   - system clock
//   rst_n - synchronous active-low reset
//   raw   - asynchronous button input
//   level - debounced button level
//   press - one-cycle pulse on an accepted rising edge
// -----------------------------------------------------------------------------
module btn_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);

  logic             sync1_reg;
  logic             sync2_reg;
  logic             level_reg;
  logic             press_reg;
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      level_reg <= 1'b0;
      press_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
      press_reg <= 1'b0;
      if (sync2_reg != level_reg) begin
        // This sample is the DEB_CYCLES-th differing one in a row.
        if (cnt_reg == CNT_W'(DEB_CYCLES - 1)) begin
          level_reg <= sync2_reg;
          press_reg <= sync2_reg;
          cnt_reg   <= '0;
        end else begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end else begin
        // Any sample matching the current level restarts the run.
        cnt_reg <= '0;
      end
    end
  end

  assign level = level_reg;
  assign press = press_reg;

endmodule

// File: rtl/whack_round_ctrl.sv
// -----------------------------------------------------------------------------
// whack_round_ctrl
// Game-round controller: arms the countdown timer each round, picks the active
// mole from an LFSR, debounces the player buttons, scores hits, charges misses
// and timeouts against lives, and shortens the timer interval as hits add up.
//   clk        - system clock
//   rst_n      - synchronous active-low reset
//   start_btn  - raw start button (async, active-high)
//   hit_btn    - raw mole buttons (async, active-high)
//   tmr        - timer link (reset_signal/interval/dir out, timeout in)
//   mole       - one-hot active mole LEDs, zero outside WAIT
//   score      - saturating hit count
//   lives      - remaining lives
//   game_over  - high in OVER
// -----------------------------------------------------------------------------
module whack_round_ctrl
  import whack_pkg::*;
#(
  parameter int         NUM_MOLES      = 4,
  parameter int         DEB_CYCLES     = 16,
  parameter int         START_INTERVAL = 5,
  parameter int         MIN_INTERVAL   = 1,
  parameter int         HITS_PER_LEVEL = 4,
  parameter int         LIVES          = 3,
  parameter logic [7:0] LFSR_SEED      = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_btn,
  input  logic [NUM_MOLES-1:0]  hit_btn,
  whack_round_ctrl_if.master    tmr,
  output logic [NUM_MOLES-1:0]  mole,
  output logic [SCORE_W-1:0]    score,
  output logic [1:0]            lives,
  output logic                  game_over
);

  localparam int IDX_W = (NUM_MOLES > 1) ? $clog2(NUM_MOLES) : 1;
  localparam int HIT_W = $clog2(HITS_PER_LEVEL + 1);

  localparam logic [INTERVAL_W-1:0] START_IV = INTERVAL_W'(START_INTERVAL);
  localparam logic [INTERVAL_W-1:0] MIN_IV   = INTERVAL_W'(MIN_INTERVAL);

  // Debounced buttons
  logic                 start_press;
  logic                 start_level;
  logic [NUM_MOLES-1:0] hit_press;
  logic [NUM_MOLES-1:0] hit_level;
  logic                 unused_levels;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_start_deb (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (start_btn),
    .level (start_level),
    .press (start_press)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MOLES; gi++) begin : g_hit_deb
      btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (hit_btn[gi]),
        .level (hit_level[gi]),
        .press (hit_press[gi])
      );
    end
  endgenerate

  // Only the press pulses drive the game; levels are not needed here.
  assign unused_levels = ^{start_level, hit_level};

  // Registered state and outputs
  state_t                state_reg;
  logic                  reset_signal_reg;
  logic [INTERVAL_W-1:0] interval_reg;
  logic [NUM_MOLES-1:0]  mole_reg;
  logic [SCORE_W-1:0]    score_reg;
  logic [1:0]            lives_reg;
  logic                  game_over_reg;
  logic [HIT_W-1:0]      hit_cnt_reg;
  logic [7:0]            lfsr_reg;

  logic [NUM_MOLES-1:0]  mole_sel;
  logic                  right_press;
  logic                  wrong_press;
  logic                  hit_event;
  logic                  miss_event;

  always_comb begin
    mole_sel    = NUM_MOLES'(1) << lfsr_reg[IDX_W-1:0];
    right_press = |(hit_press & mole_reg);
    wrong_press = |(hit_press & ~mole_reg);
    // A wrong press anywhere beats a correct one; a correct press beats timeout.
    hit_event   = right_press && !wrong_press;
    miss_event  = wrong_press || (!right_press && tmr.timeout);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      reset_signal_reg <= 1'b1;
      interval_reg     <= START_IV;
      mole_reg         <= '0;
      score_reg        <= '0;
      lives_reg        <= 2'd0;
      game_over_reg    <= 1'b0;
      hit_cnt_reg      <= '0;
      lfsr_reg         <= LFSR_SEED;
    end else begin
      lfsr_reg <= lfsr_step(lfsr_reg);

      case (state_reg)
        IDLE, OVER: begin
          if (start_press) begin
            state_reg        <= ARM;
            score_reg        <= '0;
            lives_reg        <= 2'(LIVES);
            interval_reg     <= START_IV;
            hit_cnt_reg      <= '0;
            game_over_reg    <= 1'b0;
            reset_signal_reg <= 1'b1;
            mole_reg         <= '0;
          end
        end

        ARM: begin
          mole_reg         <= mole_sel;
          reset_signal_reg <= 1'b0;
          state_reg        <= WAIT;
        end

        WAIT: begin
          if (hit_event) begin
            state_reg        <= HIT;
            mole_reg         <= '0;
            reset_signal_reg <= 1'b1;
            if (score_reg != {SCORE_W{1'b1}}) begin
              score_reg <= score_reg + SCORE_W'(1);
            end
            if (hit_cnt_reg == HIT_W'(HITS_PER_LEVEL - 1)) begin
              hit_cnt_reg <= '0;
              if (interval_reg > MIN_IV) begin
                interval_reg <= interval_reg - INTERVAL_W'(1);
              end
            end else begin
              hit_cnt_reg <= hit_cnt_reg + HIT_W'(1);
            end
          end else if (miss_event) begin
            state_reg        <= MISS;
            mole_reg         <= '0;
            reset_signal_reg <= 1'b1;
            lives_reg        <= lives_reg - 2'd1;
          end
        end

        HIT: begin
          state_reg <= ARM;
        end

        MISS: begin
          // lives_reg already holds the decremented value here.
          if (lives_reg == 2'd0) begin
            state_reg     <= OVER;
            game_over_reg <= 1'b1;
          end else begin
            state_reg <= ARM;
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign tmr.reset_signal = reset_signal_reg;
  assign tmr.interval     = interval_reg;
  assign tmr.dir          = 1'b0;
  assign mole             = mole_reg;
  assign score            = score_reg;
  assign lives            = lives_reg;
  assign game_over        = game_over_reg;

endmodule

// File: tb/tb_whack_round_ctrl.sv
// -----------------------------------------------------------------------------
// tb_whack_round_ctrl
// Self-checking bench for whack_round_ctrl with DEB_CYCLES = 4. Game rules are
// tracked with plain integers (score, lives, interval, hit count) and the mole
// is predicted from a bench-side LFSR.
// -----------------------------------------------------------------------------
module tb_whack_round_ctrl;

  localparam int NM  = 4;
  localparam int DEB = 4;
  localparam int HPL = 4;
  localparam int MIN_IV = 1;

  logic          clk;
  logic          rst_n;
  logic          start_btn;
  logic [NM-1:0] hit_btn;
  logic [NM-1:0] mole;
  logic [7:0]    score;
  logic [1:0]    lives;
  logic          game_over;

  whack_round_ctrl_if tmr();

  whack_round_ctrl #(
    .NUM_MOLES      (NM),
    .DEB_CYCLES     (DEB),
    .START_INTERVAL (5),
    .MIN_INTERVAL   (MIN_IV),
    .HITS_PER_LEVEL (HPL),
    .LIVES          (3),
    .LFSR_SEED      (8'hA5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_btn (start_btn),
    .hit_btn   (hit_btn),
    .tmr       (tmr),
    .mole      (mole),
    .score     (score),
    .lives     (lives),
    .game_over (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Game model
  int exp_score;
  int exp_lives;
  int exp_interval;
  int hits;

  // Bench LFSR: value now and value during the previous cycle.
  logic [7:0] m_lfsr;
  logic [7:0] m_lfsr_prev;
  always @(posedge clk) begin
    if (!rst_n) begin
      m_lfsr      <= 8'hA5;
      m_lfsr_prev <= 8'hA5;
    end else begin
      m_lfsr_prev <= m_lfsr;
      m_lfsr      <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end
  end

  // When the mole lights up, the prediction comes from the LFSR value held
  // during the preceding (ARM) cycle.
  logic [NM-1:0] pred_mole;
  int            pred_idx;
  logic [NM-1:0] last_mole;
  initial begin
    pred_mole = '0;
    pred_idx  = 0;
    last_mole = '0;
  end
  always begin
    @(posedge clk);
    #1;
    if (mole != '0 && last_mole == '0) begin
      pred_idx  = int'(m_lfsr_prev[1:0]);
      pred_mole = NM'(1) << pred_idx;
    end
    last_mole = mole;
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic model_new_game();
    exp_score    = 0;
    exp_lives    = 3;
    exp_interval = 5;
    hits         = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({tmr.reset_signal, tmr.interval, tmr.dir, mole, score, lives, game_over} !==
        {1'b1, 3'd5, 1'b0, 4'b0000, 8'd0, 2'd0, 1'b0}) begin
      bad++;
      $display("FAIL reset_values got rs=%b iv=%0d dir=%b mole=%b score=%0d lives=%0d go=%b want rs=1 iv=5 dir=0 mole=0000 score=0 lives=0 go=0",
               tmr.reset_signal, tmr.interval, tmr.dir, mole, score, lives, game_over);
    end
    rst_n = 1'b1;
    @(negedge clk);
    $display("reset: rs=%b iv=%0d lives=%0d", tmr.reset_signal, tmr.interval, lives);
  endtask

  task automatic test_start_bounce();
    start_btn = 1'b1;
    @(negedge clk);
    start_btn = 1'b0;
    @(negedge clk);
    start_btn = 1'b1;                 // last raw edge
    repeat (6) @(negedge clk);        // press pulse now high, FSM still IDLE
    total++;
    if (lives !== 2'd0 || mole !== '0) begin
      bad++;
      $display("FAIL start_early got lives=%0d mole=%b want lives=0 mole=0000", lives, mole);
    end
    @(negedge clk);                   // ARM
    model_new_game();
    total++;
    if (lives !== 2'd3 || tmr.reset_signal !== 1'b1 || mole !== '0 || score !== 8'd0) begin
      bad++;
      $display("FAIL start_arm got lives=%0d rs=%b mole=%b score=%0d want lives=3 rs=1 mole=0000 score=0",
               lives, tmr.reset_signal, mole, score);
    end
    @(negedge clk);                   // WAIT
    total++;
    if (tmr.reset_signal !== 1'b0 || mole !== pred_mole) begin
      bad++;
      $display("FAIL start_wait got rs=%b mole=%b want rs=0 mole=%b", tmr.reset_signal, mole, pred_mole);
    end
    $display("start: lives=%0d mole=%b", lives, mole);
    start_btn = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic wait_mole_on(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (mole != '0) seen = 1'b1;
    end
  endtask

  task automatic hit_round(input int delay, input bit with_timeout);
    bit seen;
    int idx;
    wait_mole_on(seen);
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL hit_wait_mole got=%b want=nonzero", mole);
      return;
    end
    total++;
    if (mole !== pred_mole || tmr.reset_signal !== 1'b0) begin
      bad++;
      $display("FAIL hit_mole got mole=%b rs=%b want mole=%b rs=0", mole, tmr.reset_signal, pred_mole);
    end
    idx = pred_idx;
    repeat (delay) @(negedge clk);
    hit_btn[idx] = 1'b1;
    if (with_timeout) begin
      // Timeout lands in the same cycle as the press pulse.
      repeat (6) @(negedge clk);
      tmr.timeout = 1'b1;
      @(negedge clk);
      tmr.timeout = 1'b0;
    end else begin
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        if (mole == '0) seen = 1'b1;
      end
      total++;
      if (!seen) begin
        bad++;
        $display("FAIL hit_no_response got mole=%b want=0000", mole);
      end
    end
    hits++;
    exp_score = (exp_score >= 255) ? 255 : exp_score + 1;
    if (hits % HPL == 0 && exp_interval > MIN_IV) exp_interval--;
    total++;
    if (mole !== '0 || int'(score) != exp_score || int'(tmr.interval) != exp_interval ||
        int'(lives) != exp_lives || tmr.reset_signal !== 1'b1) begin
      bad++;
      $display("FAIL hit_result got mole=%b score=%0d iv=%0d lives=%0d rs=%b want mole=0000 score=%0d iv=%0d lives=%0d rs=1",
               mole, score, tmr.interval, lives, tmr.reset_signal, exp_score, exp_interval, exp_lives);
    end
    $display("hit: idx=%0d to=%0b score=%0d iv=%0d lives=%0d", idx, with_timeout, score, tmr.interval, lives);
    hit_btn = '0;
    repeat (8) @(negedge clk);
  endtask

  task automatic miss_round(input bit wrong);
    bit seen;
    int idx;
    wait_mole_on(seen);
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL miss_wait_mole got=%b want=nonzero", mole);
      return;
    end
    if (wrong) begin
      idx = (pred_idx + 1 + int'($urandom_range(0, 2))) % NM;
      hit_btn[idx] = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        if (mole == '0) seen = 1'b1;
      end
      total++;
      if (!seen) begin
        bad++;
        $display("FAIL miss_no_response got mole=%b want=0000", mole);
      end
    end else begin
      tmr.timeout = 1'b1;
      @(negedge clk);
      tmr.timeout = 1'b0;
    end
    exp_lives--;
    total++;
    if (mole !== '0 || int'(lives) != exp_lives || int'(score) != exp_score || tmr.reset_signal !== 1'b1) begin
      bad++;
      $display("FAIL miss_result got mole=%b lives=%0d score=%0d rs=%b want mole=0000 lives=%0d score=%0d rs=1",
               mole, lives, score, tmr.reset_signal, exp_lives, exp_score);
    end
    if (exp_lives == 0) begin
      @(negedge clk);
      total++;
      if (game_over !== 1'b1 || mole !== '0 || int'(score) != exp_score) begin
        bad++;
        $display("FAIL game_over got go=%b mole=%b score=%0d want go=1 mole=0000 score=%0d",
                 game_over, mole, score, exp_score);
      end
    end
    $display("miss: wrong=%0b lives=%0d go=%b", wrong, lives, game_over);
    hit_btn = '0;
    repeat (8) @(negedge clk);
  endtask

  task automatic start_game();
    @(negedge clk);
    start_btn = 1'b1;
    repeat (8) @(negedge clk);
    start_btn = 1'b0;
    repeat (8) @(negedge clk);
    model_new_game();
    total++;
    if (int'(lives) != exp_lives || game_over !== 1'b0 || score !== 8'd0 || int'(tmr.interval) != exp_interval) begin
      bad++;
      $display("FAIL start_game got lives=%0d go=%b score=%0d iv=%0d want lives=3 go=0 score=0 iv=5",
               lives, game_over, score, tmr.interval);
    end
    $display("start_game: lives=%0d score=%0d", lives, score);
  endtask

  task automatic test_hits();
    for (int n = 0; n < 8; n++) hit_round(int'($urandom_range(0, 3)), 1'b0);
  endtask

  task automatic test_same_cycle();
    hit_round(int'($urandom_range(0, 2)), 1'b1);
    miss_round(1'b1);
  endtask

  task automatic test_reset_mid();
    bit seen;
    wait_mole_on(seen);
    total++;
    if (!seen || score == 8'd0) begin
      bad++;
      $display("FAIL reset_mid_setup got mole=%b score=%0d want mole!=0 score!=0", mole, score);
    end
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if ({tmr.reset_signal, tmr.interval, mole, score, lives, game_over} !==
        {1'b1, 3'd5, 4'b0000, 8'd0, 2'd0, 1'b0}) begin
      bad++;
      $display("FAIL reset_mid got rs=%b iv=%0d mole=%b score=%0d lives=%0d go=%b want rs=1 iv=5 mole=0000 score=0 lives=0 go=0",
               tmr.reset_signal, tmr.interval, mole, score, lives, game_over);
    end
    rst_n = 1'b1;
    $display("reset_mid: score=%0d mole=%b", score, mole);
  endtask

  task automatic test_idle_ignore();
    hit_btn     = 4'b1111;
    tmr.timeout = 1'b1;
    @(negedge clk);
    tmr.timeout = 1'b0;
    repeat (8) @(negedge clk);
    total++;
    if (mole !== '0 || score !== 8'd0 || lives !== 2'd0 || tmr.reset_signal !== 1'b1) begin
      bad++;
      $display("FAIL idle_ignore got mole=%b score=%0d lives=%0d rs=%b want mole=0000 score=0 lives=0 rs=1",
               mole, score, lives, tmr.reset_signal);
    end
    hit_btn = '0;
    repeat (8) @(negedge clk);
    $display("idle_ignore: mole=%b score=%0d", mole, score);
  endtask

  task automatic test_game_over();
    start_game();
    for (int n = 0; n < 3; n++) miss_round(1'b0);
    tmr.timeout = 1'b1;
    @(negedge clk);
    tmr.timeout = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (lives !== 2'd0 || game_over !== 1'b1 || mole !== '0) begin
      bad++;
      $display("FAIL over_hold got lives=%0d go=%b mole=%b want lives=0 go=1 mole=0000", lives, game_over, mole);
    end
    start_game();
  endtask

  task automatic test_saturate();
    for (int n = 0; n < 258; n++) hit_round(int'($urandom_range(0, 2)), 1'b0);
    total++;
    if (score !== 8'd255 || tmr.interval !== 3'd1) begin
      bad++;
      $display("FAIL saturate got score=%0d iv=%0d want score=255 iv=1", score, tmr.interval);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    start_btn   = 1'b0;
    hit_btn     = '0;
    tmr.timeout = 1'b0;
    model_new_game();
    test_reset();
    test_start_bounce();
    test_hits();
    test_same_cycle();
    test_reset_mid();
    test_idle_ignore();
    test_game_over();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
